rob_commit_ring: RTL and testbench



---
 rtl/rob_pkg.sv | 24 ++
 rtl/rob_commit_select.sv | 47 ++++
 rtl/rob_commit_ring.sv | 163 ++++++++++++++++
 tb/tb_rob_commit_ring.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared sizing, entry payload and status types for the reorder buffer.
package rob_pkg;
  localparam int ROB_ENTRIES   = 8;
  localparam int INSTR_Q_WIDTH = 2;
  localparam int PHYS_W        = 7;

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2,
    ST_EXC  = 2'd3
  } rob_status_t;

  typedef struct packed {
    logic [63:0]       pc;
    logic [7:0]        uopcode;
    logic              is_store;
    logic [4:0]        dest_arch;
    logic [PHYS_W-1:0] dest_phys;
    logic [PHYS_W-1:0] old_phys;
    logic [PHYS_W-1:0] st_addr_phys;
    logic [PHYS_W-1:0] st_data_phys;
  } rob_slot_t;
endpackage

// File: rtl/rob_commit_select.sv
// Combinational in-order retire scan over the head lanes; stops at the first
// lane that cannot retire and flags it when that lane holds an exception.
module rob_commit_select
  import rob_pkg::*;
#(
  parameter int COMMIT_W = 2,
  parameter int CNT_W    = 4,
  localparam int RW      = $clog2(COMMIT_W + 1)
) (
  input  logic                en_i,
  input  logic [CNT_W-1:0]    count_i,
  input  logic                store_ready_i,
  input  rob_status_t         lane_status_i [COMMIT_W],
  input  logic [COMMIT_W-1:0] lane_store_i,
  output logic [COMMIT_W-1:0] retire_o,
  output logic [RW-1:0]       n_retire_o,
  output logic                exc_o,
  output logic [RW-1:0]       exc_lane_o
);
  always_comb begin
    logic go;
    logic store_used;
    retire_o   = '0;
    n_retire_o = '0;
    exc_o      = 1'b0;
    exc_lane_o = '0;
    go         = en_i;
    store_used = 1'b0;
    for (int j = 0; j < COMMIT_W; j++) begin
      if (go && (int'(count_i) > j)) begin
        // The store commit path takes at most one store per cycle.
        if (lane_status_i[j] == ST_DONE &&
            (!lane_store_i[j] || (store_ready_i && !store_used))) begin
          retire_o[j] = 1'b1;
          n_retire_o  = n_retire_o + 1'b1;
          store_used  = store_used | lane_store_i[j];
        end else begin
          exc_o      = (lane_status_i[j] == ST_EXC);
          exc_lane_o = RW'(j);
          go         = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
    end
  end
endmodule

// File: rtl/rob_commit_ring.sv
// Circular ROB: multi-wide allocate at tail, out-of-order writeback, in-order commit
// from head (combinational, same-edge retire); head exception -> one TRAP cycle and squash.
module rob_commit_ring
  import rob_pkg::*;
#(
  parameter int                   DEPTH      = ROB_ENTRIES,
  parameter int                   DISPATCH_W = INSTR_Q_WIDTH,
  parameter int                   COMMIT_W   = 2,
  parameter int                   WB_PORTS   = 4,
  parameter int                   ADDR_BITS  = 64,
  parameter logic [ADDR_BITS-1:0] TRAP_VEC   = '0,
  localparam int                  IDX_W      = $clog2(DEPTH),
  localparam int                  CNT_W      = $clog2(DEPTH + 1),
  localparam int                  DW         = $clog2(DISPATCH_W + 1)
) (
  input  logic                 clk_in,
  input  logic                 rst_N_in,
  input  logic                 flush_in,
  input  logic [DW-1:0]        disp_count_in,
  input  rob_slot_t            disp_entries_in [DISPATCH_W],
  output logic                 disp_ready_out,
  output logic [IDX_W-1:0]     disp_idx_out [DISPATCH_W],
  input  logic [WB_PORTS-1:0]  wb_valid_in,
  input  logic [IDX_W-1:0]     wb_idx_in [WB_PORTS],
  input  logic [WB_PORTS-1:0]  wb_exc_in,
  input  logic                 store_ready_in,
  output logic [COMMIT_W-1:0]  commit_valid_out,
  output rob_slot_t            commit_slot_out [COMMIT_W],
  output logic                 redirect_valid_out,
  output logic [ADDR_BITS-1:0] redirect_pc_out,
  output logic [ADDR_BITS-1:0] epc_out,
  output logic [CNT_W-1:0]     count_out,
  output logic                 full_out,
  output logic                 empty_out
);
  localparam int PW = IDX_W + 1;
  localparam int RW = $clog2(COMMIT_W + 1);

  typedef enum logic {S_RUN, S_TRAP} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        head_q, head_d, tail_q, tail_d, count;
  rob_status_t          status_q [DEPTH];
  rob_status_t          status_d [DEPTH];
  rob_slot_t            slot_q [DEPTH];
  rob_slot_t            slot_d [DEPTH];
  logic [ADDR_BITS-1:0] epc_q, epc_d;

  rob_status_t          lane_status [COMMIT_W];
  logic [COMMIT_W-1:0]  lane_store, retire;
  logic [RW-1:0]        n_retire, exc_lane;
  logic                 exc_hit, scan_en, do_disp;

  // Wrap bit on head/tail separates full from empty when the low bits match.
  assign count          = tail_q - head_q;
  assign scan_en        = (state_q == S_RUN) && !flush_in;
  assign disp_ready_out = (state_q == S_RUN) && ((PW'(DEPTH) - count) >= PW'(DISPATCH_W));
  assign do_disp        = disp_ready_out && (disp_count_in != '0);

  assign commit_valid_out   = retire;
  assign redirect_valid_out = (state_q == S_TRAP);
  assign redirect_pc_out    = redirect_valid_out ? TRAP_VEC : '0;
  assign epc_out            = epc_q;
  assign count_out          = CNT_W'(count);
  assign full_out           = (count == PW'(DEPTH));
  assign empty_out          = (count == '0);

  always_comb begin
    logic [IDX_W-1:0] li;
    li = '0;
    for (int j = 0; j < COMMIT_W; j++) begin
      li                 = head_q[IDX_W-1:0] + IDX_W'(j);
      lane_status[j]     = status_q[li];
      lane_store[j]      = slot_q[li].is_store;
      commit_slot_out[j] = slot_q[li];
    end
    for (int i = 0; i < DISPATCH_W; i++) begin
      disp_idx_out[i] = tail_q[IDX_W-1:0] + IDX_W'(i);
    end
  end

  rob_commit_select #(
    .COMMIT_W(COMMIT_W),
    .CNT_W   (PW)
  ) u_sel (
    .en_i         (scan_en),
    .count_i      (count),
    .store_ready_i(store_ready_in),
    .lane_status_i(lane_status),
    .lane_store_i (lane_store),
    .retire_o     (retire),
    .n_retire_o   (n_retire),
    .exc_o        (exc_hit),
    .exc_lane_o   (exc_lane)
  );

  always_comb begin
    logic [IDX_W-1:0] wi;
    wi       = '0;
    state_d  = state_q;
    head_d   = head_q;
    tail_d   = tail_q;
    status_d = status_q;
    slot_d   = slot_q;
    epc_d    = epc_q;
    if (flush_in || state_q == S_TRAP) begin
      state_d = S_RUN;
      head_d  = '0;
      tail_d  = '0;
      for (int k = 0; k < DEPTH; k++) status_d[k] = ST_FREE;
    end else begin
      for (int j = 0; j < COMMIT_W; j++) begin
        if (retire[j]) begin
          wi           = head_q[IDX_W-1:0] + IDX_W'(j);
          status_d[wi] = ST_FREE;
        end
      end
      head_d = head_q + PW'(n_retire);
      if (exc_hit) begin
        state_d = S_TRAP;
        wi      = head_q[IDX_W-1:0] + IDX_W'(exc_lane);
        epc_d   = ADDR_BITS'(slot_q[wi].pc);
      end
      // Only BUSY targets complete; an exception on any port for the index wins.
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid_in[p] && status_q[wb_idx_in[p]] == ST_BUSY) begin
          status_d[wb_idx_in[p]] =
            (wb_exc_in[p] || status_d[wb_idx_in[p]] == ST_EXC) ? ST_EXC : ST_DONE;
        end
      end
      if (do_disp) begin
        for (int i = 0; i < DISPATCH_W; i++) begin
          if (DW'(i) < disp_count_in) begin
            wi           = tail_q[IDX_W-1:0] + IDX_W'(i);
            slot_d[wi]   = disp_entries_in[i];
            status_d[wi] = ST_BUSY;
          end
        end
        tail_d = tail_q + PW'(disp_count_in);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state_q <= S_RUN;
      head_q  <= '0;
      tail_q  <= '0;
      epc_q   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        status_q[k] <= ST_FREE;
        slot_q[k]   <= '0;
      end
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      epc_q    <= epc_d;
      status_q <= status_d;
      slot_q   <= slot_d;
    end
  end
endmodule

// File: tb/tb_rob_commit_ring.sv
// Directed and randomised checks of rob_commit_ring against a queue-based ROB model.
`timescale 1ns/1ps
module tb_rob_commit_ring;
  import rob_pkg::*;

  localparam int          DEPTH    = 8;
  localparam int          DISP_W   = 2;
  localparam int          COMMIT_W = 2;
  localparam int          WB_PORTS = 4;
  localparam logic [63:0] TVEC     = 64'h0000_0000_0000_1000;
  localparam int          M_BUSY   = 1;
  localparam int          M_DONE   = 2;
  localparam int          M_EXC    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n, flush, store_ready, disp_ready, redirect_valid, full, empty;
  logic [1:0]          disp_count;
  rob_slot_t           disp_entries [DISP_W];
  logic [2:0]          disp_idx [DISP_W];
  logic [WB_PORTS-1:0] wb_valid, wb_exc;
  logic [2:0]          wb_idx [WB_PORTS];
  logic [COMMIT_W-1:0] commit_valid;
  rob_slot_t           commit_slot [COMMIT_W];
  logic [63:0]         redirect_pc, epc;
  logic [3:0]          count;

  int total = 0;
  int bad   = 0;

  // Reference: occupied entries in program order (index 0 = head) plus head position.
  int          qstat[$];
  rob_slot_t   qslot[$];
  int          mhead   = 0;
  bit          mtrap   = 1'b0;
  logic [63:0] mepc    = '0;
  logic [63:0] next_pc = 64'h2000;

  rob_commit_ring #(
    .DEPTH(DEPTH), .DISPATCH_W(DISP_W), .COMMIT_W(COMMIT_W), .WB_PORTS(WB_PORTS),
    .ADDR_BITS(64), .TRAP_VEC(TVEC)
  ) dut (
    .clk_in(clk), .rst_N_in(rst_n), .flush_in(flush),
    .disp_count_in(disp_count), .disp_entries_in(disp_entries),
    .disp_ready_out(disp_ready), .disp_idx_out(disp_idx),
    .wb_valid_in(wb_valid), .wb_idx_in(wb_idx), .wb_exc_in(wb_exc),
    .store_ready_in(store_ready),
    .commit_valid_out(commit_valid), .commit_slot_out(commit_slot),
    .redirect_valid_out(redirect_valid), .redirect_pc_out(redirect_pc),
    .epc_out(epc), .count_out(count), .full_out(full), .empty_out(empty)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    disp_count  = '0;
    wb_valid    = '0;
    wb_exc      = '0;
    flush       = 1'b0;
    store_ready = 1'b1;
    for (int i = 0; i < WB_PORTS; i++) wb_idx[i] = '0;
    for (int i = 0; i < DISP_W; i++) disp_entries[i] = '0;
  endtask

  function automatic rob_slot_t mk_slot(input logic [63:0] pc, input bit st);
    rob_slot_t s;
    s.pc           = pc;
    s.uopcode      = 8'($urandom);
    s.is_store     = st;
    s.dest_arch    = 5'($urandom);
    s.dest_phys    = 7'($urandom);
    s.old_phys     = 7'($urandom);
    s.st_addr_phys = 7'($urandom);
    s.st_data_phys = 7'($urandom);
    return s;
  endfunction

  task automatic disp(input int n, input bit st, input logic [63:0] pc0);
    disp_count = 2'(n);
    for (int i = 0; i < DISP_W; i++) disp_entries[i] = mk_slot(pc0 + 64'(4 * i), st);
  endtask

  task automatic wb(input int p, input int idx, input bit exc);
    wb_valid[p] = 1'b1;
    wb_idx[p]   = 3'(idx);
    wb_exc[p]   = exc;
  endtask

  task automatic model_reset();
    qstat.delete();
    qslot.delete();
    mhead = 0;
    mtrap = 1'b0;
    mepc  = '0;
  endtask

  // Called just after a rising edge: checks mid-cycle, advances the model, crosses the edge.
  task automatic step();
    int          sz, n, pos;
    bit          stop_exc, st_used, rdy;
    int          ns[$];
    logic [1:0]  exp_cv;
    #3;
    sz       = qstat.size();
    n        = 0;
    stop_exc = 1'b0;
    st_used  = 1'b0;
    if (!mtrap && !flush) begin
      for (int j = 0; j < COMMIT_W && j < sz; j++) begin
        if (qstat[j] == M_DONE && (!qslot[j].is_store || (store_ready && !st_used))) begin
          n++;
          if (qslot[j].is_store) st_used = 1'b1;
        end else begin
          stop_exc = (qstat[j] == M_EXC);
          break;
        end
      end
    end
    exp_cv = (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
    rdy    = !mtrap && ((DEPTH - sz) >= DISP_W);

    chk("commit_valid", 128'(commit_valid), 128'(exp_cv));
    for (int j = 0; j < n; j++) chk("commit_slot", 128'(commit_slot[j]), 128'(qslot[j]));
    chk("count", 128'(count), 128'(sz));
    chk("full", 128'(full), 128'(sz == DEPTH));
    chk("empty", 128'(empty), 128'(sz == 0));
    chk("disp_ready", 128'(disp_ready), 128'(rdy));
    chk("redirect_valid", 128'(redirect_valid), 128'(mtrap));
    chk("redirect_pc", 128'(redirect_pc), 128'(mtrap ? TVEC : 64'h0));
    chk("epc", 128'(epc), 128'(mepc));
    for (int i = 0; i < DISP_W; i++)
      chk("disp_idx", 128'(disp_idx[i]), 128'((mhead + sz + i) % DEPTH));

    if (flush || mtrap) begin
      qstat.delete();
      qslot.delete();
      mhead = 0;
      mtrap = 1'b0;
    end else begin
      ns = qstat;
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p]) begin
          pos = (int'(wb_idx[p]) - mhead + DEPTH) % DEPTH;
          if (pos < sz && qstat[pos] == M_BUSY)
            ns[pos] = (wb_exc[p] || ns[pos] == M_EXC) ? M_EXC : M_DONE;
        end
      end
      if (stop_exc) begin
        mtrap = 1'b1;
        mepc  = qslot[n].pc;
      end
      qstat = ns;
      repeat (n) begin
        qstat.delete(0);
        qslot.delete(0);
      end
      mhead = (mhead + n) % DEPTH;
      if (rdy) begin
        for (int i = 0; i < int'(disp_count); i++) begin
          qstat.push_back(M_BUSY);
          qslot.push_back(disp_entries[i]);
        end
      end
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    #2;
    chk("rst_ready", 128'(disp_ready), 128'(1));
    chk("rst_empty", 128'(empty), 128'(1));
    chk("rst_full", 128'(full), 128'(0));
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_commit", 128'(commit_valid), 128'(0));
    chk("rst_redirect", 128'(redirect_valid), 128'(0));
    chk("rst_epc", 128'(epc), 128'(0));
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill to full; tail wraps back to index 0.
    for (int c = 0; c < 4; c++) begin
      disp(2, 1'b0, 64'(c * 8));
      step();
    end
    #1;
    chk("fill_count", 128'(count), 128'(8));
    chk("fill_full", 128'(full), 128'(1));
    chk("fill_ready", 128'(disp_ready), 128'(0));
    chk("tail_wrap", 128'(disp_idx[0]), 128'(0));

    // Out-of-order completion: idx1 first holds commit until idx0 completes.
    disp(2, 1'b0, 64'h80);
    wb(0, 1, 1'b0);
    step();
    #1;
    chk("ooo_hold", 128'(commit_valid), 128'(2'b00));
    wb(0, 0, 1'b0);
    step();
    #1;
    chk("ooo_pair", 128'(commit_valid), 128'(2'b11));
    wb(0, 2, 1'b0); wb(1, 3, 1'b0); wb(2, 4, 1'b0); wb(3, 5, 1'b0);
    step();
    wb(0, 6, 1'b0); wb(1, 7, 1'b0);
    step();
    repeat (3) step();
    #1;
    chk("drained", 128'(empty), 128'(1));

    // Two completed stores at head: one retires per cycle.
    disp(2, 1'b1, 64'h100);
    step();
    wb(0, 0, 1'b0); wb(1, 1, 1'b0);
    step();
    #1;
    chk("store_one", 128'(commit_valid), 128'(2'b01));
    step();
    #1;
    chk("store_two", 128'(commit_valid), 128'(2'b01));
    chk("store_cnt", 128'(count), 128'(1));
    step();

    // Asynchronous reset with entries in flight clears without a clock edge.
    disp(2, 1'b0, 64'h180);
    step();
    rst_n = 1'b0;
    #1;
    chk("arst_count", 128'(count), 128'(0));
    chk("arst_empty", 128'(empty), 128'(1));
    model_reset();
    rst_n = 1'b1;

    // idx0 DONE, idx1 EXC at pc 0x40.
    disp(2, 1'b0, 64'h3c);
    step();
    wb(0, 0, 1'b0); wb(1, 1, 1'b1);
    step();
    #1;
    chk("exc_lane0", 128'(commit_valid), 128'(2'b01));
    step();
    #1;
    chk("trap_redirect", 128'(redirect_valid), 128'(1));
    chk("trap_pc", 128'(redirect_pc), 128'(TVEC));
    chk("trap_epc", 128'(epc), 128'(64'h40));
    chk("trap_ready", 128'(disp_ready), 128'(0));
    disp(2, 1'b0, 64'h300);
    step();
    #1;
    chk("trap_exit_empty", 128'(empty), 128'(1));
    chk("trap_exit_ready", 128'(disp_ready), 128'(1));

    // Flush with 5 entries, head DONE, plus same-cycle dispatch and writeback.
    disp(2, 1'b0, 64'h400); step();
    disp(2, 1'b0, 64'h408); step();
    disp(1, 1'b0, 64'h410); step();
    wb(0, 0, 1'b0);
    step();
    flush = 1'b1;
    disp(2, 1'b0, 64'h500);
    wb(0, 1, 1'b0);
    step();
    #1;
    chk("flush_count", 128'(count), 128'(0));
    chk("flush_commit", 128'(commit_valid), 128'(0));

    // Writeback to a FREE index is ignored; dual-port hit on idx1 with one exc -> EXC.
    disp(2, 1'b0, 64'h600);
    step();
    wb(0, 5, 1'b1); wb(1, 1, 1'b0); wb(2, 1, 1'b1);
    step();
    wb(0, 0, 1'b0);
    step();
    #1;
    chk("dual_exc_stop", 128'(commit_valid), 128'(2'b01));
    step();
    #1;
    chk("dual_redirect", 128'(redirect_valid), 128'(1));
    chk("dual_epc", 128'(epc), 128'(64'h604));
    step();

    // Randomised traffic.
    for (int c = 0; c < 600; c++) begin
      flush       = ($urandom_range(0, 39) == 0);
      store_ready = ($urandom_range(0, 3) != 0);
      disp_count  = 2'($urandom_range(0, 2));
      for (int i = 0; i < DISP_W; i++) begin
        disp_entries[i] = mk_slot(next_pc, $urandom_range(0, 2) == 0);
        next_pc = next_pc + 64'h4;
      end
      for (int p = 0; p < WB_PORTS; p++) begin
        if ($urandom_range(0, 1) == 1)
          wb(p, int'($urandom_range(0, 7)), $urandom_range(0, 15) == 0);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
